// File: rtl/i2c_bus_conditioner_if.sv
// Master-side I2C pin bundle: raw pins and controls in, clean levels and event strobes out.
interface i2c_bus_conditioner_if;
    logic iEn;
    logic iSCL_raw;
    logic iSDA_raw;
    logic iTimeoutClr;
    logic oSCL;
    logic oSDA;
    logic oSCL_rise;
    logic oSCL_fall;
    logic oStart;
    logic oRepStart;
    logic oStop;
    logic oBusBusy;
    logic oTimeout;

    modport master (
        output iEn, iSCL_raw, iSDA_raw, iTimeoutClr,
        input  oSCL, oSDA, oSCL_rise, oSCL_fall, oStart, oRepStart, oStop, oBusBusy, oTimeout
    );

    modport slave (
        input  iEn, iSCL_raw, iSDA_raw, iTimeoutClr,
        output oSCL, oSDA, oSCL_rise, oSCL_fall, oStart, oRepStart, oStop, oBusBusy, oTimeout
    );
endinterface

// File: rtl/i2c_bus_conditioner.sv
// Synchronizes and deglitches raw SCL/SDA, emits edge/START/STOP strobes and tracks
// bus ownership with a stuck-low SCL timeout.
module i2c_bus_conditioner #(
    parameter int FILT_CNT = 3,
    parameter int TO_W     = 20,
    parameter int TO_LIMIT = 625000
) (
    input  logic                   iClk,
    input  logic                   iRstn,
    i2c_bus_conditioner_if.slave   bus
);
    typedef enum logic [1:0] {IDLE, BUSY, TIMEOUT} busStateT;

    localparam logic [3:0]      FILT_LAST = 4'(FILT_CNT - 1);
    localparam logic [TO_W-1:0] TO_LAST   = TO_W'(TO_LIMIT - 1);

    // Bit 0 carries SCL, bit 1 carries SDA through the whole front end.
    logic [1:0]      sync1, sync2, filt, filtPrev;
    logic [1:0][3:0] filtCnt;

    busStateT        state, stateNext;
    logic [TO_W-1:0] toCnt, toCntNext;
    logic            sclRiseQ, sclFallQ, startQ, repStartQ, stopQ, busyQ;
    logic            startNext, repStartNext, stopNext, busyNext;
    logic            sclUp, sclDn, startCond, stopCond;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge iClk or negedge iRstn) begin
        if (!iRstn) begin
            sync1    <= 2'b11;
            sync2    <= 2'b11;
            filt     <= 2'b11;
            filtPrev <= 2'b11;
            filtCnt  <= '0;
        end else begin
            sync1    <= {bus.iSDA_raw, bus.iSCL_raw};
            sync2    <= sync1;
            filtPrev <= filt;
            for (int i = 0; i < 2; i++) begin
                if (sync2[i] == filt[i]) begin
                    filtCnt[i] <= '0;
                end else if (filtCnt[i] == FILT_LAST) begin
                    filt[i]    <= sync2[i];
                    filtCnt[i] <= '0;
                end else begin
                    filtCnt[i] <= filtCnt[i] + 4'd1;
                end
            end
        end
    end

    // SCL must be high and stable across both samples, so a simultaneous SCL change masks START/STOP.
    assign sclUp     = filt[0] & ~filtPrev[0];
    assign sclDn     = ~filt[0] & filtPrev[0];
    assign startCond = filtPrev[1] & ~filt[1] & filt[0] & filtPrev[0];
    assign stopCond  = ~filtPrev[1] & filt[1] & filt[0] & filtPrev[0];

    // NOTE: every output of this block is defaulted first, so no path can infer a latch.
    always_comb begin
        stateNext    = state;
        toCntNext    = toCnt;
        startNext    = 1'b0;
        repStartNext = 1'b0;
        stopNext     = 1'b0;
        if (!bus.iEn) begin
            stateNext = IDLE;
            toCntNext = '0;
        end else begin
            unique case (state)
                IDLE: begin
                    toCntNext = '0;
                    if (startCond) begin
                        stateNext = BUSY;
                        startNext = 1'b1;
                    end else if (stopCond) begin
                        stopNext = 1'b1;
                    end
                end
                BUSY: begin
                    if (startCond) begin
                        repStartNext = 1'b1;
                        toCntNext    = '0;
                    end else if (stopCond) begin
                        stopNext  = 1'b1;
                        stateNext = IDLE;
                        toCntNext = '0;
                    end else if (sclRiseQ) begin
                        toCntNext = '0;
                    end else if (!filt[0]) begin
                        if (toCnt == TO_LAST) begin
                            stateNext = TIMEOUT;
                            toCntNext = '0;
                        end else if (toCnt != '1) begin
                            toCntNext = toCnt + TO_W'(1);
                        end
                    end
                end
                TIMEOUT: begin
                    toCntNext = '0;
                    if (bus.iTimeoutClr && filt[0] && filt[1]) stateNext = IDLE;
                end
                default: begin
                    stateNext = IDLE;
                    toCntNext = '0;
                end
            endcase
        end
        // Busy covers the STOP strobe cycle itself so consumers see the closing event while owned.
        busyNext = (stateNext == BUSY) || (state == BUSY && stopNext);
    end

    always_ff @(posedge iClk or negedge iRstn) begin
        if (!iRstn) begin
            state     <= IDLE;
            toCnt     <= '0;
            sclRiseQ  <= 1'b0;
            sclFallQ  <= 1'b0;
            startQ    <= 1'b0;
            repStartQ <= 1'b0;
            stopQ     <= 1'b0;
            busyQ     <= 1'b0;
        end else begin
            state     <= stateNext;
            toCnt     <= toCntNext;
            sclRiseQ  <= bus.iEn & sclUp;
            sclFallQ  <= bus.iEn & sclDn;
            startQ    <= startNext;
            repStartQ <= repStartNext;
            stopQ     <= stopNext;
            busyQ     <= busyNext;
        end
    end

    assign bus.oSCL      = filt[0];
    assign bus.oSDA      = filt[1];
    assign bus.oSCL_rise = sclRiseQ;
    assign bus.oSCL_fall = sclFallQ;
    assign bus.oStart    = startQ;
    assign bus.oRepStart = repStartQ;
    assign bus.oStop     = stopQ;
    assign bus.oBusBusy  = busyQ & bus.iEn;
    assign bus.oTimeout  = (state == TIMEOUT) & bus.iEn;
endmodule

// File: tb/tb_i2c_bus_conditioner.sv
// Directed plus randomized bench for i2c_bus_conditioner, scored each cycle against a
// behavioural model of the I2C pin-conditioning rules.
module tb_i2c_bus_conditioner;
    localparam int FILT     = 3;
    localparam int TO_LIM   = 100;
    localparam int M_IDLE   = 0;
    localparam int M_BUSY   = 1;
    localparam int M_TIMEOUT = 2;

    logic iClk = 1'b0;
    logic iRstn;
    i2c_bus_conditioner_if bus();

    i2c_bus_conditioner #(.FILT_CNT(FILT), .TO_W(20), .TO_LIMIT(TO_LIM)) dut (
        .iClk (iClk),
        .iRstn(iRstn),
        .bus  (bus.slave)
    );

    always #20 iClk = ~iClk;

    int checks = 0;
    int fails  = 0;

    // Behavioural model state
    logic mSq[$];
    logic mDq[$];
    logic mScl = 1'b1, mSda = 1'b1, mSclPrev = 1'b1, mSdaPrev = 1'b1;
    int   mSclRun = 0, mSdaRun = 0, mMode = M_IDLE, mLow = 0;
    logic mRise = 0, mFall = 0, mStart = 0, mRep = 0, mStop = 0, mBusy = 0;

    // Observed pulse tallies
    int   rises, falls, starts, reps, stops;
    logic busySeen, sdaMin;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clearTallies();
        rises = 0; falls = 0; starts = 0; reps = 0; stops = 0;
        busySeen = 1'b0; sdaMin = 1'b1;
    endtask

    task automatic modelEdge();
        logic s, d, oScl, oSda, pScl, pSda, startC, stopC, oldRise, en;
        int nextMode;
        s = mSq.pop_front(); mSq.push_back(bus.iSCL_raw);
        d = mDq.pop_front(); mDq.push_back(bus.iSDA_raw);
        oScl = mScl; oSda = mSda; pScl = mSclPrev; pSda = mSdaPrev;
        oldRise = mRise; en = bus.iEn;
        startC = pSda && !oSda && oScl && pScl;
        stopC  = !pSda && oSda && oScl && pScl;
        mRise = en && oScl && !pScl;
        mFall = en && !oScl && pScl;
        mStart = 0; mRep = 0; mStop = 0;
        nextMode = mMode;
        if (!en) begin
            nextMode = M_IDLE;
        end else if (mMode == M_IDLE) begin
            if (startC) begin nextMode = M_BUSY; mStart = 1; end
            else if (stopC) mStop = 1;
        end else if (mMode == M_BUSY) begin
            if (startC) begin mRep = 1; mLow = 0; end
            else if (stopC) begin mStop = 1; nextMode = M_IDLE; end
            else if (oldRise) mLow = 0;
            else if (!oScl) begin
                if (mLow == TO_LIM - 1) nextMode = M_TIMEOUT;
                else mLow++;
            end
        end else begin
            if (bus.iTimeoutClr && oScl && oSda) nextMode = M_IDLE;
        end
        mBusy = (nextMode == M_BUSY) || (mMode == M_BUSY && mStop);
        mMode = nextMode;
        if (mMode != M_BUSY) mLow = 0;
        if (s != mScl) begin
            mSclRun++;
            if (mSclRun == FILT) begin mScl = s; mSclRun = 0; end
        end else mSclRun = 0;
        if (d != mSda) begin
            mSdaRun++;
            if (mSdaRun == FILT) begin mSda = d; mSdaRun = 0; end
        end else mSdaRun = 0;
        mSclPrev = oScl;
        mSdaPrev = oSda;
    endtask

    // One clock: model advances at the edge, outputs are scored at the falling edge.
    task automatic step();
        logic [8:0] obs, exp;
        @(posedge iClk);
        modelEdge();
        @(negedge iClk);
        obs = {bus.oSCL, bus.oSDA, bus.oSCL_rise, bus.oSCL_fall, bus.oStart,
               bus.oRepStart, bus.oStop, bus.oBusBusy, bus.oTimeout};
        exp = {mScl, mSda, mRise, mFall, mStart, mRep, mStop,
               mBusy && bus.iEn, (mMode == M_TIMEOUT) && bus.iEn};
        check("cycle_outputs", 32'(obs), 32'(exp));
        rises  += int'(bus.oSCL_rise);
        falls  += int'(bus.oSCL_fall);
        starts += int'(bus.oStart);
        reps   += int'(bus.oRepStart);
        stops  += int'(bus.oStop);
        busySeen |= bus.oBusBusy;
        sdaMin   &= bus.oSDA;
    endtask

    task automatic cyc(input int n);
        repeat (n) step();
    endtask

    task automatic lines(input logic scl, input logic sda, input int n);
        bus.iSCL_raw = scl;
        bus.iSDA_raw = sda;
        cyc(n);
    endtask

    task automatic sclPulse(input logic bitVal, input int h);
        bus.iSCL_raw = 1'b0; cyc(h);
        bus.iSDA_raw = bitVal; cyc(h);
        bus.iSCL_raw = 1'b1; cyc(h);
    endtask

    initial begin
        int n;
        int h;
        mSq = {1'b1, 1'b1};
        mDq = {1'b1, 1'b1};
        clearTallies();
        bus.iEn = 1'b1; bus.iTimeoutClr = 1'b0;
        bus.iSCL_raw = 1'b0; bus.iSDA_raw = 1'b0;
        iRstn = 1'b0;

        // Reset with both raw lines low: outputs idle-high, no strobes.
        repeat (2) @(negedge iClk);
        check("reset_outputs", 32'({bus.oSCL, bus.oSDA, bus.oSCL_rise, bus.oSCL_fall, bus.oStart,
              bus.oRepStart, bus.oStop, bus.oBusBusy, bus.oTimeout}), 32'h180);
        iRstn = 1'b1;
        n = 0;
        while (bus.oSCL !== 1'b0 && n < 20) begin step(); n++; end
        check("reset_release_latency", 32'(n), 32'(2 + FILT));
        check("reset_release_sda", 32'(bus.oSDA), 32'h0);
        lines(1'b1, 1'b1, 12);

        // Glitch rejection on SDA with SCL high.
        clearTallies();
        lines(1'b1, 1'b0, 1); lines(1'b1, 1'b1, 10);
        lines(1'b1, 1'b0, 2); lines(1'b1, 1'b1, 10);
        check("glitch_sda_held", 32'(sdaMin), 32'h1);
        check("glitch_no_start", 32'(starts), 32'h0);
        lines(1'b1, 1'b0, 3); lines(1'b1, 1'b1, 12);
        check("pulse3_sda_fell", 32'(sdaMin), 32'h0);
        check("pulse3_start", 32'(starts), 32'h1);
        check("pulse3_stop", 32'(stops), 32'h1);

        // Full transaction with randomized half-periods and data.
        clearTallies();
        h = $urandom_range(4, 7);
        lines(1'b1, 1'b0, h);
        for (int i = 0; i < 9; i++) sclPulse((i == 8) ? 1'b1 : 1'($urandom), h);
        lines(1'b1, 1'b0, h);
        for (int i = 0; i < 9; i++) sclPulse((i == 8) ? 1'b0 : 1'($urandom), h);
        lines(1'b1, 1'b1, 10);
        check("txn_start", 32'(starts), 32'h1);
        check("txn_rises", 32'(rises), 32'd18);
        check("txn_repstart", 32'(reps), 32'h1);
        check("txn_stop", 32'(stops), 32'h1);
        check("txn_busy_after", 32'(bus.oBusBusy), 32'h0);

        // SCL and SDA raw changes in the same clock.
        clearTallies();
        lines(1'b0, 1'b0, 10);
        lines(1'b1, 1'b1, 10);
        check("simul_fall", 32'(falls), 32'h1);
        check("simul_rise", 32'(rises), 32'h1);
        check("simul_no_events", 32'(starts + stops + reps), 32'h0);

        // Stuck-low SCL timeout and its clear conditions.
        clearTallies();
        lines(1'b1, 1'b0, 8);
        bus.iSCL_raw = 1'b0;
        n = 0;
        while (bus.oSCL !== 1'b0 && n < 20) begin step(); n++; end
        n = 0;
        while (bus.oTimeout !== 1'b1 && n < 300) begin step(); n++; end
        check("timeout_latency", 32'(n), 32'(TO_LIM));
        check("timeout_busy_drop", 32'(bus.oBusBusy), 32'h0);
        lines(1'b1, 1'b0, 8);
        bus.iTimeoutClr = 1'b1; cyc(2); bus.iTimeoutClr = 1'b0; cyc(2);
        check("timeout_clr_sda_low", 32'(bus.oTimeout), 32'h1);
        lines(1'b1, 1'b1, 8);
        check("timeout_stop_suppressed", 32'(stops), 32'h0);
        check("timeout_still_set", 32'(bus.oTimeout), 32'h1);
        bus.iTimeoutClr = 1'b1; cyc(1); bus.iTimeoutClr = 1'b0; cyc(1);
        check("timeout_cleared", 32'(bus.oTimeout), 32'h0);

        // Enable low during a START/STOP sequence, then re-enable with idle lines.
        clearTallies();
        bus.iEn = 1'b0;
        lines(1'b1, 1'b0, 8); lines(1'b0, 1'b0, 8); lines(1'b1, 1'b0, 8); lines(1'b1, 1'b1, 8);
        check("disabled_no_strobes", 32'(rises + falls + starts + reps + stops), 32'h0);
        check("disabled_no_busy", 32'(busySeen), 32'h0);
        bus.iEn = 1'b1;
        cyc(10);
        check("reenable_quiet", 32'(rises + falls + starts + reps + stops), 32'h0);
        lines(1'b1, 1'b0, 8);
        check("reenable_start", 32'(starts), 32'h1);
        check("reenable_busy", 32'(bus.oBusBusy), 32'h1);
        lines(1'b1, 1'b1, 8);
        check("reenable_stop", 32'(stops), 32'h1);

        // Randomized pin activity with occasional long SCL-low holds.
        for (int i = 0; i < 4000; i++) begin
            if (i % 700 == 350) begin
                bus.iEn = 1'b1; bus.iTimeoutClr = 1'b0;
                lines(1'b1, 1'b1, 6); lines(1'b1, 1'b0, 6);
                lines(1'b0, 1'b0, $urandom_range(90, 130));
            end
            if ($urandom_range(0, 5) == 0) bus.iSCL_raw = ~bus.iSCL_raw;
            if ($urandom_range(0, 5) == 0) bus.iSDA_raw = ~bus.iSDA_raw;
            bus.iEn = ($urandom_range(0, 99) != 0);
            bus.iTimeoutClr = ($urandom_range(0, 7) == 0);
            step();
        end

        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end
endmodule

// File: doc/i2c_bus_conditioner.md
Name: i2c_bus_conditioner

Overview:
Front-end stage for the I2C mux/buffer path. It synchronizes and deglitches the raw master-side SCL/SDA pins and produces clean levels plus single-cycle event strobes: SCL rise/fall, START, repeated START and STOP. It also tracks bus ownership and detects a stuck-low SCL. The mux decoder consumes these outputs instead of sampling raw pins. Runs on the 25 MHz system clock.

Parameters:
FILT_CNT, 3, consecutive synced samples a new level must hold before the filtered output changes (1..15)
TO_W, 20, width of the SCL-low timeout counter
TO_LIMIT, 625000, SCL-low cycles in BUSY before timeout (25 ms at 25 MHz); must fit in TO_W bits

Ports:
iClk  in  1  system clock, 25 MHz
iRstn  in  1  asynchronous active-low reset
iEn  in  1  block enable; 0 holds FSM in IDLE and suppresses all event strobes
iSCL_raw  in  1  raw SCL pin level
iSDA_raw  in  1  raw SDA pin level
iTimeoutClr  in  1  software clear of timeout condition
oSCL  out  1  filtered SCL level
oSDA  out  1  filtered SDA level
oSCL_rise  out  1  one-cycle pulse on filtered SCL 0->1
oSCL_fall  out  1  one-cycle pulse on filtered SCL 1->0
oStart  out  1  one-cycle pulse, START detected from IDLE
oRepStart  out  1  one-cycle pulse, START detected while BUSY
oStop  out  1  one-cycle pulse, STOP detected
oBusBusy  out  1  level, high from START until STOP or timeout
oTimeout  out  1  level, high in TIMEOUT state

Behaviour:
- Reset: reset iRstn, asynchronous, active-low; clock iClk. On reset, sync flops = 1, oSCL = oSDA = 1, all strobes = 0, oBusBusy = 0, oTimeout = 0, filter and timeout counters = 0, FSM = IDLE.
- Sync: 2-FF synchronizer per line.
- Filter, per line, independent: if synced level == filtered level, counter clears. Otherwise counter increments; when it reaches FILT_CNT-1 and the level still differs, the filtered output takes the new level and the counter clears. A pulse shorter than FILT_CNT cycles never reaches the output. Latency from a raw edge to the filtered edge = 2 + FILT_CNT cycles.
- Edge strobes: registered compare of the current vs previous filtered value. A strobe is asserted the cycle after the filtered change and lasts exactly 1 cycle.
- START condition: filtered SDA 1->0 in a cycle where filtered SCL is 1 now and was 1 in the previous cycle.
- STOP condition: filtered SDA 0->1 with the same SCL requirement.
- Simultaneous SCL and SDA change in the same cycle: no START/STOP; only the SCL edge strobe fires.
- FSM states: IDLE, BUSY, TIMEOUT.
  - IDLE: on START -> BUSY, pulse oStart. STOP -> pulse oStop, stay IDLE.
  - BUSY: oBusBusy = 1. START -> pulse oRepStart, stay BUSY, timeout counter cleared. STOP -> pulse oStop, go IDLE. Timeout counter increments each cycle oSCL == 0 and clears on oSCL_rise. When the counter reaches TO_LIMIT-1 while oSCL is still 0 -> TIMEOUT.
  - TIMEOUT: oTimeout = 1, oBusBusy = 0. START/STOP strobes suppressed. Go IDLE only when iTimeoutClr = 1 and oSCL = oSDA = 1 in the same cycle. iTimeoutClr outside TIMEOUT has no effect.
- Strobe timing: oStart/oRepStart/oStop are asserted in the same cycle as the FSM state change they cause.
- iEn = 0:
  - FSM forced to IDLE next cycle, timeout counter cleared, oBusBusy = oTimeout = 0.
  - All five strobes held at 0.
  - Sync and filter keep running, so oSCL/oSDA stay valid.
  - On iEn 0->1, no event is generated from levels that were already stable.
- Timeout counter saturates; it never wraps.

Test Plan:
- Reset: hold iRstn = 0 with raw lines = 0 -> oSCL = oSDA = 1, all strobes 0. Release -> oSCL/oSDA fall 2+3 = 5 cycles after the first clock.
- Glitch reject (FILT_CNT = 3): SDA low pulses of 1 and 2 cycles with SCL high -> oSDA stays 1, no oStart. 3-cycle pulse -> oSDA falls, oStart pulses once.
- Full transaction: START, 9 SCL pulses, repeated START, 9 SCL pulses, STOP -> oStart = 1, oSCL_rise count = 18, oRepStart = 1, oStop = 1. oBusBusy high from the oStart cycle through the oStop cycle.
- Simultaneous edge: SCL and SDA raw change in the same clock -> only oSCL_rise or oSCL_fall pulses, no START/STOP.
- Timeout (TO_LIMIT = 100): START, then hold SCL low -> oTimeout rises exactly 100 SCL-low cycles later and oBusBusy drops. iTimeoutClr with SDA low -> stays TIMEOUT. iTimeoutClr with both lines high -> IDLE.
- Enable: iEn = 0 during a START/STOP sequence -> no strobes, oBusBusy = 0. Raise iEn with lines idle -> no spurious strobes. A subsequent START is detected normally.
